// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter between the CPU data path (m0) and the loader/debug master (m1)
// onto the shared memory write port and read port 1, with load slicing and extension.
module mem_access_arbiter #(
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clock_in,
  input  logic                     reset_in,

  input  logic                     m0_req_in,
  input  logic                     m0_write_in,
  input  logic [1:0]               m0_mode_in,
  input  logic                     m0_unsigned_in,
  input  logic [ADDRESS_WIDTH-1:0] m0_address_in,
  input  logic [31:0]              m0_write_data_in,
  output logic                     m0_grant_out,
  output logic                     m0_rvalid_out,
  output logic                     m0_error_out,
  output logic [31:0]              m0_read_data_out,

  input  logic                     m1_req_in,
  input  logic                     m1_write_in,
  input  logic [1:0]               m1_mode_in,
  input  logic                     m1_unsigned_in,
  input  logic [ADDRESS_WIDTH-1:0] m1_address_in,
  input  logic [31:0]              m1_write_data_in,
  output logic                     m1_grant_out,
  output logic                     m1_rvalid_out,
  output logic                     m1_error_out,
  output logic [31:0]              m1_read_data_out,

  output logic                     mem_write_out,
  output logic [1:0]               mem_mode_out,
  output logic [ADDRESS_WIDTH-1:0] mem_write_address_out,
  output logic [31:0]              mem_write_data_out,
  output logic [ADDRESS_WIDTH-1:0] mem_read_address_out,
  output logic                     mem_read_en_out,
  input  logic [31:0]              mem_read_data_in
);

  // last_m1 = 1 means m1 won most recently, so m0 wins the next tie
  logic       last_m1_q, last_m1_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_m1_q, rsp_m1_d;
  logic       rsp_err_q, rsp_err_d;
  logic [1:0] rsp_mode_q, rsp_mode_d;
  logic [1:0] rsp_off_q, rsp_off_d;
  logic       rsp_uns_q, rsp_uns_d;

  logic                     granted;
  logic                     sel_m1;
  logic                     sel_write;
  logic [1:0]               sel_mode;
  logic                     sel_uns;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [31:0]              sel_wdata;
  logic                     misaligned;
  logic                     do_write;
  logic                     do_read;

  always_comb begin
    m0_grant_out = 1'b0;
    m1_grant_out = 1'b0;
    if (!reset_in) begin
      m0_grant_out = m0_req_in & (~m1_req_in | last_m1_q);
      m1_grant_out = m1_req_in & (~m0_req_in | ~last_m1_q);
    end
    granted   = m0_grant_out | m1_grant_out;
    sel_m1    = m1_grant_out;
    sel_write = sel_m1 ? m1_write_in      : m0_write_in;
    sel_mode  = sel_m1 ? m1_mode_in       : m0_mode_in;
    sel_uns   = sel_m1 ? m1_unsigned_in   : m0_unsigned_in;
    sel_addr  = sel_m1 ? m1_address_in    : m0_address_in;
    sel_wdata = sel_m1 ? m1_write_data_in : m0_write_data_in;

    case (sel_mode)
      2'b10:   misaligned = sel_addr[0];
      2'b11:   misaligned = 1'b0;
      default: misaligned = |sel_addr[1:0];
    endcase

    do_write = granted & sel_write & ~misaligned;
    do_read  = granted & ~sel_write & ~misaligned;

    mem_write_out         = do_write;
    mem_mode_out          = do_write ? sel_mode  : 2'b00;
    mem_write_address_out = do_write ? sel_addr  : '0;
    mem_write_data_out    = do_write ? sel_wdata : 32'h0;
    mem_read_address_out  = do_read  ? sel_addr  : '0;
  end

  always_comb begin
    last_m1_d   = granted ? sel_m1 : last_m1_q;
    rsp_valid_d = granted & (~sel_write | misaligned);
    rsp_m1_d    = sel_m1;
    rsp_err_d   = misaligned;
    rsp_mode_d  = sel_mode;
    rsp_off_d   = sel_addr[1:0];
    rsp_uns_d   = sel_uns;
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      last_m1_q   <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_m1_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_mode_q  <= 2'b00;
      rsp_off_q   <= 2'b00;
      rsp_uns_q   <= 1'b0;
    end else begin
      last_m1_q   <= last_m1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_m1_q    <= rsp_m1_d;
      rsp_err_q   <= rsp_err_d;
      rsp_mode_q  <= rsp_mode_d;
      rsp_off_q   <= rsp_off_d;
      rsp_uns_q   <= rsp_uns_d;
    end
  end

  // Response stage: the memory returns the word addressed in the grant cycle
  logic        rsp_live;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] load_fmt;

  always_comb begin
    rsp_live        = rsp_valid_q & ~reset_in;
    mem_read_en_out = rsp_live & ~rsp_err_q;

    half_sel = rsp_off_q[1] ? mem_read_data_in[31:16] : mem_read_data_in[15:0];
    case (rsp_off_q)
      2'b00:   byte_sel = mem_read_data_in[7:0];
      2'b01:   byte_sel = mem_read_data_in[15:8];
      2'b10:   byte_sel = mem_read_data_in[23:16];
      default: byte_sel = mem_read_data_in[31:24];
    endcase

    case (rsp_mode_q)
      2'b10:   load_fmt = {{16{~rsp_uns_q & half_sel[15]}}, half_sel};
      2'b11:   load_fmt = {{24{~rsp_uns_q & byte_sel[7]}}, byte_sel};
      default: load_fmt = mem_read_data_in;
    endcase
    if (rsp_err_q) load_fmt = 32'h0;

    m0_rvalid_out    = rsp_live & ~rsp_m1_q;
    m1_rvalid_out    = rsp_live & rsp_m1_q;
    m0_error_out     = m0_rvalid_out & rsp_err_q;
    m1_error_out     = m1_rvalid_out & rsp_err_q;
    m0_read_data_out = m0_rvalid_out ? load_fmt : 32'h0;
    m1_read_data_out = m1_rvalid_out ? load_fmt : 32'h0;
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: byte-array memory behind the DUT, a transaction-level
// reference model checked every cycle, and directed sequences with literal expectations.
module tb_mem_access_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m0_req, m0_wr, m0_uns, m1_req, m1_wr, m1_uns;
  logic [1:0]  m0_mode, m1_mode;
  logic [7:0]  m0_addr, m1_addr;
  logic [31:0] m0_wd, m1_wd;
  logic        m0_gnt, m0_rv, m0_err, m1_gnt, m1_rv, m1_err;
  logic [31:0] m0_rd, m1_rd;
  logic        mem_wr, mem_ren;
  logic [1:0]  mem_mode;
  logic [7:0]  mem_waddr, mem_raddr;
  logic [31:0] mem_wdata, mem_rdata;

  mem_access_arbiter #(.ADDRESS_WIDTH(8)) dut (
    .clock_in(clk), .reset_in(rst),
    .m0_req_in(m0_req), .m0_write_in(m0_wr), .m0_mode_in(m0_mode), .m0_unsigned_in(m0_uns),
    .m0_address_in(m0_addr), .m0_write_data_in(m0_wd), .m0_grant_out(m0_gnt),
    .m0_rvalid_out(m0_rv), .m0_error_out(m0_err), .m0_read_data_out(m0_rd),
    .m1_req_in(m1_req), .m1_write_in(m1_wr), .m1_mode_in(m1_mode), .m1_unsigned_in(m1_uns),
    .m1_address_in(m1_addr), .m1_write_data_in(m1_wd), .m1_grant_out(m1_gnt),
    .m1_rvalid_out(m1_rv), .m1_error_out(m1_err), .m1_read_data_out(m1_rd),
    .mem_write_out(mem_wr), .mem_mode_out(mem_mode), .mem_write_address_out(mem_waddr),
    .mem_write_data_out(mem_wdata), .mem_read_address_out(mem_raddr),
    .mem_read_en_out(mem_ren), .mem_read_data_in(mem_rdata)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(logic [1:0] mode);
    if (mode[1] == 1'b0) return 4;
    return mode[0] ? 1 : 2;
  endfunction

  // Memory device behind the DUT: stores commit at the clock edge, read address is registered
  logic [7:0] dev_mem [256];
  logic [7:0] dev_raddr_q = 8'h00;
  int         dev_n;
  assign dev_n = nbytes(mem_mode);

  always @(posedge clk) begin
    if (mem_wr)
      for (int i = 0; i < 4; i++)
        if (i < dev_n) dev_mem[mem_waddr + 8'(i)] <= mem_wdata[8*i +: 8];
    dev_raddr_q <= mem_raddr;
  end

  assign mem_rdata = {dev_mem[{dev_raddr_q[7:2], 2'b11}], dev_mem[{dev_raddr_q[7:2], 2'b10}],
                      dev_mem[{dev_raddr_q[7:2], 2'b01}], dev_mem[{dev_raddr_q[7:2], 2'b00}]};

  // Reference model: a byte-addressed memory plus "who went last" and one pending response
  logic [7:0] ref_mem [256];

  function automatic logic [31:0] ref_load(logic [7:0] a, logic [1:0] mode, logic uns);
    logic [31:0] w, mask, v;
    int          n;
    int          sh;
    n  = nbytes(mode);
    w  = {ref_mem[a + 8'd3 - 8'(a % 4)], ref_mem[a + 8'd2 - 8'(a % 4)],
          ref_mem[a + 8'd1 - 8'(a % 4)], ref_mem[a - 8'(a % 4)]};
    if (n == 4) return w;
    sh   = 8 * (int'(a) % 4);
    mask = (32'd1 << (8 * n)) - 32'd1;
    v    = (w >> sh) & mask;
    if (!uns && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  int          last_m = 1;
  logic        p_v = 1'b0, p_m1 = 1'b0, p_err = 1'b0;
  logic [31:0] p_data = 32'h0;
  logic        e_g0, e_g1, s_wr, s_uns, s_mis, e_mw, e_rd, e_rv0, e_rv1;
  logic [1:0]  s_mode;
  logic [7:0]  s_addr;
  logic [31:0] s_wd;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      e_g0 = 1'b0; e_g1 = 1'b0;
    end else if (m0_req && m1_req) begin
      e_g0 = (last_m == 1); e_g1 = !e_g0;
    end else begin
      e_g0 = m0_req; e_g1 = m1_req;
    end
    s_wr   = e_g1 ? m1_wr   : m0_wr;
    s_mode = e_g1 ? m1_mode : m0_mode;
    s_uns  = e_g1 ? m1_uns  : m0_uns;
    s_addr = e_g1 ? m1_addr : m0_addr;
    s_wd   = e_g1 ? m1_wd   : m0_wd;
    s_mis  = (e_g0 || e_g1) && ((int'(s_addr) % nbytes(s_mode)) != 0);
    e_mw   = (e_g0 || e_g1) && s_wr && !s_mis;
    e_rd   = (e_g0 || e_g1) && !s_wr && !s_mis;
    e_rv0  = !rst && p_v && !p_m1;
    e_rv1  = !rst && p_v && p_m1;

    chk1("m0_grant", m0_gnt, e_g0);
    chk1("m1_grant", m1_gnt, e_g1);
    chk1("mem_write", mem_wr, e_mw);
    chk32("mem_mode", 32'(mem_mode), e_mw ? 32'(s_mode) : 32'h0);
    chk8("mem_waddr", mem_waddr, e_mw ? s_addr : 8'h00);
    chk32("mem_wdata", mem_wdata, e_mw ? s_wd : 32'h0);
    chk8("mem_raddr", mem_raddr, e_rd ? s_addr : 8'h00);
    chk1("mem_read_en", mem_ren, !rst && p_v && !p_err);
    chk1("m0_rvalid", m0_rv, e_rv0);
    chk1("m1_rvalid", m1_rv, e_rv1);
    chk1("m0_error", m0_err, e_rv0 && p_err);
    chk1("m1_error", m1_err, e_rv1 && p_err);
    chk32("m0_rdata", m0_rd, e_rv0 ? p_data : 32'h0);
    chk32("m1_rdata", m1_rd, e_rv1 ? p_data : 32'h0);

    p_v = 1'b0;
    if (rst) begin
      last_m = 1;
    end else if (e_g0 || e_g1) begin
      last_m = e_g1 ? 1 : 0;
      p_m1   = e_g1;
      p_err  = s_mis;
      if (s_mis) begin
        p_v = 1'b1; p_data = 32'h0;
      end else if (s_wr) begin
        for (int i = 0; i < nbytes(s_mode); i++) ref_mem[s_addr + 8'(i)] = s_wd[8*i +: 8];
      end else begin
        p_v = 1'b1; p_data = ref_load(s_addr, s_mode, s_uns);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(int m, logic req, logic wr, logic [1:0] mode, logic uns,
                       logic [7:0] addr, logic [31:0] wd);
    if (m == 0) begin
      m0_req = req; m0_wr = wr; m0_mode = mode; m0_uns = uns; m0_addr = addr; m0_wd = wd;
    end else begin
      m1_req = req; m1_wr = wr; m1_mode = mode; m1_uns = uns; m1_addr = addr; m1_wd = wd;
    end
  endtask

  task automatic idle();
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  // One isolated load: grant in this cycle, literal result in the next
  task automatic load_lit(string name, int m, logic [1:0] mode, logic uns, logic [7:0] addr,
                          logic [31:0] exp);
    step();
    set_m(m, 1'b1, 1'b0, mode, uns, addr, 32'h0);
    @(negedge clk);
    chk1({name, "_grant"}, (m == 0) ? m0_gnt : m1_gnt, 1'b1);
    step();
    idle();
    @(negedge clk);
    chk1({name, "_rvalid"}, (m == 0) ? m0_rv : m1_rv, 1'b1);
    chk32({name, "_data"}, (m == 0) ? m0_rd : m1_rd, exp);
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [1:0]  mode;
    logic        uns;
    logic [31:0] exp;
  } load_vec_t;

  load_vec_t fmt_vecs [7] = '{
    '{8'h20, 2'b11, 1'b0, 32'h0000_0001},
    '{8'h21, 2'b11, 1'b0, 32'h0000_007F},
    '{8'h22, 2'b11, 1'b0, 32'hFFFF_FFFF},
    '{8'h23, 2'b11, 1'b0, 32'hFFFF_FF80},
    '{8'h23, 2'b11, 1'b1, 32'h0000_0080},
    '{8'h22, 2'b10, 1'b0, 32'hFFFF_80FF},
    '{8'h20, 2'b10, 1'b1, 32'h0000_7F01}
  };

  initial begin
    rst = 1'b1;
    set_m(0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 32'h0);
    set_m(1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Preload the formatting word through m1
    step();
    set_m(1, 1'b1, 1'b1, 2'b00, 1'b0, 8'h20, 32'h80FF_7F01);
    @(negedge clk);
    chk1("preload_grant", m1_gnt, 1'b1);

    // m0 store then back-to-back load of the same word
    step();
    idle();
    set_m(0, 1'b1, 1'b1, 2'b00, 1'b0, 8'h10, 32'hDEAD_BEEF);
    @(negedge clk);
    chk1("st_grant", m0_gnt, 1'b1);
    chk1("st_mem_write", mem_wr, 1'b1);
    chk32("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    step();
    set_m(0, 1'b1, 1'b0, 2'b00, 1'b0, 8'h10, 32'h0);
    @(negedge clk);
    chk1("ld_grant", m0_gnt, 1'b1);
    chk1("st_no_rvalid", m0_rv, 1'b0);
    chk1("ld_ren_early", mem_ren, 1'b0);
    step();
    idle();
    @(negedge clk);
    chk1("ld_rvalid", m0_rv, 1'b1);
    chk32("ld_data", m0_rd, 32'hDEAD_BEEF);
    chk1("ld_ren", mem_ren, 1'b1);
    step();
    @(negedge clk);
    chk1("ld_ren_after", mem_ren, 1'b0);

    foreach (fmt_vecs[i])
      load_lit($sformatf("fmt%0d", i), i % 2, fmt_vecs[i].mode, fmt_vecs[i].uns,
               fmt_vecs[i].addr, fmt_vecs[i].exp);

    // Reset right after an m1 load grant, with both requesting during reset
    step();
    set_m(1, 1'b1, 1'b0, 2'b00, 1'b0, 8'h20, 32'h0);
    @(negedge clk);
    chk1("rst_m1_grant", m1_gnt, 1'b1);
    step();
    rst = 1'b1;
    set_m(0, 1'b1, 1'b0, 2'b00, 1'b0, 8'h10, 32'h0);
    @(negedge clk);
    chk1("rst_drop_rvalid", m1_rv, 1'b0);
    chk1("rst_no_grant0", m0_gnt, 1'b0);
    chk1("rst_no_grant1", m1_gnt, 1'b0);

    // Both masters hold load requests for six cycles after reset
    for (int k = 0; k < 6; k++) begin
      step();
      rst = 1'b0;
      @(negedge clk);
      chk1($sformatf("rr%0d_g0", k), m0_gnt, (k % 2) == 0);
      chk1($sformatf("rr%0d_g1", k), m1_gnt, (k % 2) == 1);
      if (k > 0) begin
        chk1($sformatf("rr%0d_rv0", k), m0_rv, ((k - 1) % 2) == 0);
        chk1($sformatf("rr%0d_rv1", k), m1_rv, ((k - 1) % 2) == 1);
        if (((k - 1) % 2) == 0) chk32($sformatf("rr%0d_d0", k), m0_rd, 32'hDEAD_BEEF);
        else                    chk32($sformatf("rr%0d_d1", k), m1_rd, 32'h80FF_7F01);
      end
    end
    step();
    idle();
    @(negedge clk);
    chk1("rr_last_rv1", m1_rv, 1'b1);

    // Pointer must return to favouring m0 even when m0 won last before reset
    step();
    set_m(0, 1'b1, 1'b0, 2'b00, 1'b0, 8'h10, 32'h0);
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_m(0, 1'b1, 1'b0, 2'b00, 1'b0, 8'h10, 32'h0);
    set_m(1, 1'b1, 1'b0, 2'b00, 1'b0, 8'h20, 32'h0);
    @(negedge clk);
    chk1("ptr_reset_g0", m0_gnt, 1'b1);
    step();
    idle();

    // Misaligned word store is granted, not written, and answered with an error
    step();
    set_m(0, 1'b1, 1'b1, 2'b00, 1'b0, 8'h12, 32'h1234_5678);
    @(negedge clk);
    chk1("mis_st_grant", m0_gnt, 1'b1);
    chk1("mis_st_nowrite", mem_wr, 1'b0);
    step();
    idle();
    @(negedge clk);
    chk1("mis_st_rvalid", m0_rv, 1'b1);
    chk1("mis_st_error", m0_err, 1'b1);
    load_lit("mis_unchanged", 0, 2'b00, 1'b0, 8'h10, 32'hDEAD_BEEF);

    step();
    set_m(1, 1'b1, 1'b0, 2'b10, 1'b0, 8'h21, 32'h0);
    step();
    idle();
    @(negedge clk);
    chk1("mis_ld_error", m1_err, 1'b1);
    chk32("mis_ld_data", m1_rd, 32'h0);

    // Partial stores into the DEADBEEF word
    step();
    set_m(1, 1'b1, 1'b1, 2'b10, 1'b0, 8'h12, 32'hFFFF_ABCD);
    step();
    set_m(1, 1'b1, 1'b1, 2'b11, 1'b0, 8'h11, 32'hFFFF_FF55);
    step();
    idle();
    load_lit("partial_st", 0, 2'b00, 1'b0, 8'h10, 32'hABCD_55EF);

    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
